// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem line-port arbiter: word/line typedefs, FSM state, grant side.
// Pure declarations, no logic.
package mem_port_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [15:0]  lc3b_line_sel;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IMEM = 1'b0,
        GNT_DMEM = 1'b1
    } grant_t;

    // Bus-side fields captured from the winning requester at grant time.
    typedef struct packed {
        logic         we;
        lc3b_word     address;
        lc3b_data     wdata;
        lc3b_line_sel sel;
    } bus_req_t;

    localparam lc3b_line_sel SEL_FULL_LINE = 16'hFFFF;

endpackage

// File: rtl/mem_port_arbiter_line_write_steer.sv
// Places a 16-bit store word and its byte mask into the matching lanes of a 128-bit line.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module line_write_steer
    import mem_port_arbiter_pkg::*;
(
    input  logic [15:0]  wdata,
    input  logic [1:0]   byte_enable,
    input  logic [2:0]   word_index,   // address[3:1]: which 16-bit word of the line
    output logic [127:0] mem_wdata,
    output logic [15:0]  mem_sel
);

    // The word is copied into every lane; mem_sel alone decides which bytes land.
    assign mem_wdata = {8{wdata}};
    assign mem_sel   = lc3b_line_sel'({14'b0, byte_enable}) << {word_index, 1'b0};

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit line port between fetch (imem) and memory stage (dmem).
// Latency: request sampled in IDLE -> mem_stb next cycle; mem_ack at N -> resp pulse at N+1, IDLE at N+2.
// Backpressure: no ready; each requester holds stb/cyc until its resp pulse, the loser simply waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         imem_stb,
    input  logic         imem_cyc,
    input  logic [15:0]  imem_address,
    output logic         imem_resp,
    output logic [127:0] imem_rdata,
    input  logic         dmem_action_stb,
    input  logic         dmem_action_cyc,
    input  logic         dmem_write,
    input  logic [15:0]  dmem_address,
    input  logic [15:0]  dmem_wdata,
    input  logic [1:0]   dmem_byte_enable,
    output logic         dmem_resp,
    output logic [127:0] dmem_rdata,
    output logic         mem_stb,
    output logic         mem_cyc,
    output logic         mem_we,
    output logic [15:0]  mem_address,
    output logic [127:0] mem_wdata,
    output logic [15:0]  mem_sel,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdata,
    output logic         bus_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t   state;
    arb_state_t   state_nxt;
    grant_t       last_grant;   // doubles as the side owning the transfer in flight
    grant_t       grant_nxt;
    logic [7:0]   timeout_cnt;
    logic         imem_req;
    logic         dmem_req;
    logic         any_req;
    logic         timeout_hit;
    logic         xfer_end;
    lc3b_data     steer_wdata;
    lc3b_line_sel steer_sel;
    bus_req_t     req_nxt;
    logic         unused_addr_bits;

    assign imem_req    = imem_stb & imem_cyc;
    assign dmem_req    = dmem_action_stb & dmem_action_cyc;
    assign any_req     = imem_req | dmem_req;
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign xfer_end    = mem_ack | timeout_hit;

    // Sub-line address bits are irrelevant on a line-aligned port.
    assign unused_addr_bits = ^{imem_address[3:0], dmem_address[0]};

    line_write_steer u_steer (
        .wdata       (dmem_wdata),
        .byte_enable (dmem_byte_enable),
        .word_index  (dmem_address[3:1]),
        .mem_wdata   (steer_wdata),
        .mem_sel     (steer_sel)
    );

    always_comb begin
        grant_nxt = GNT_IMEM;
        if (imem_req && dmem_req) begin
            grant_nxt = (last_grant == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
        end else if (dmem_req) begin
            grant_nxt = GNT_DMEM;
        end
    end

    always_comb begin
        req_nxt = '0;
        if (grant_nxt == GNT_DMEM) begin
            req_nxt.we      = dmem_write;
            req_nxt.address = {dmem_address[15:4], 4'b0};
            req_nxt.wdata   = steer_wdata;
            req_nxt.sel     = dmem_write ? steer_sel : SEL_FULL_LINE;
        end else begin
            req_nxt.we      = 1'b0;
            req_nxt.address = {imem_address[15:4], 4'b0};
            req_nxt.wdata   = '0;
            req_nxt.sel     = SEL_FULL_LINE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)  state_nxt = XFER;
            XFER:    if (xfer_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= GNT_IMEM;
            timeout_cnt <= '0;
            mem_stb     <= 1'b0;
            mem_cyc     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_sel     <= '0;
            imem_resp   <= 1'b0;
            dmem_resp   <= 1'b0;
            bus_err     <= 1'b0;
            imem_rdata  <= '0;
            dmem_rdata  <= '0;
        end else begin
            imem_resp <= 1'b0;
            dmem_resp <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant  <= grant_nxt;
                        timeout_cnt <= '0;
                        mem_stb     <= 1'b1;
                        mem_cyc     <= 1'b1;
                        mem_we      <= req_nxt.we;
                        mem_address <= req_nxt.address;
                        mem_wdata   <= req_nxt.wdata;
                        mem_sel     <= req_nxt.sel;
                    end
                end
                XFER: begin
                    if (xfer_end) begin
                        mem_stb <= 1'b0;
                        mem_cyc <= 1'b0;
                        // An ack on the final timeout cycle still counts as a good transfer.
                        bus_err <= ~mem_ack;
                        if (last_grant == GNT_DMEM) begin
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            imem_resp  <= 1'b1;
                            imem_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
